// File: rtl/cla_word_sequencer.sv
// Multi-precision adder controller: streams WORD-bit slices (LSW first) through an external CLA, chaining carry.
// Latency NWORDS+1 cycles from accepted start to done; start is ignored while busy.
module cla_word_sequencer #(
  parameter int WORD   = 8,
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WORD*NWORDS-1:0]   a,
  input  logic [WORD*NWORDS-1:0]   b,
  input  logic                     cin,
  output logic                     busy,
  output logic                     done,
  output logic [WORD*NWORDS-1:0]   sum,
  output logic                     cout,
  output logic [WORD-1:0]          add_a,
  output logic [WORD-1:0]          add_b,
  output logic                     add_cin,
  input  logic [WORD-1:0]          add_w,
  input  logic                     add_cout
);

  localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IDXW-1:0]                idx;
  logic [NWORDS-1:0][WORD-1:0]    a_q;
  logic [NWORDS-1:0][WORD-1:0]    b_q;
  logic [NWORDS-1:0][WORD-1:0]    sum_q;
  logic                           carry;
  logic                           cout_q;
  logic                           last;
  logic                           accept;

  assign last   = (idx == IDXW'(NWORDS - 1));
  assign accept = start && (state != S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result slices land one per RUN edge; sum/cout are only touched in RUN so they hold across IDLE/DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else if (accept) begin
      idx   <= '0;
      a_q   <= a;
      b_q   <= b;
      carry <= cin;
    end else if (state == S_RUN) begin
      sum_q[idx] <= add_w;
      carry      <= add_cout;
      if (last) begin
        cout_q <= add_cout;
        idx    <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == S_RUN) begin
      add_a   = a_q[idx];
      add_b   = b_q[idx];
      add_cin = carry;
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
